// File: rtl/loader_sequencer_pkg.sv
// Shared types and constants for the loader sequencer.
//   state_e : top-level run FSM states
//   PMU_AW  : PMU register select width
//   PMU_DW  : PMU register data width
package loader_sequencer_pkg;
  localparam int PMU_AW = 5;
  localparam int PMU_DW = 32;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_SETTLE,
    ST_WAIT_IDLE,
    ST_DRAIN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/loader_sequencer_pmu_drain_walker.sv
// PMU drain walker: steps through every (core, register) pair, core-major,
// presents the register select, samples the data one cycle later and hands
// each word out over a valid/ready interface.
//   clk_i, arstn_i       : clock, async active-low reset
//   start_i              : pulse, begin a walk from core 0 / reg 0
//   pmu_addr_o[c]        : register select, 0 for every core not being read
//   pmu_data_i[c]        : register read data
//   res_valid_o/ready_i  : result handshake
//   res_data/core/reg_o  : result word and its origin, stable while stalled
//   last_o               : comb, final word accepted this cycle
module pmu_drain_walker
  import loader_sequencer_pkg::*;
#(
  parameter int CORE_COUNT    = 16,
  parameter int PMU_REG_COUNT = 8
) (
  input  logic                                  clk_i,
  input  logic                                  arstn_i,
  input  logic                                  start_i,
  output logic [CORE_COUNT-1:0][PMU_AW-1:0]     pmu_addr_o,
  input  logic [CORE_COUNT-1:0][PMU_DW-1:0]     pmu_data_i,
  output logic                                  res_valid_o,
  input  logic                                  res_ready_i,
  output logic [PMU_DW-1:0]                     res_data_o,
  output logic [$clog2(CORE_COUNT)-1:0]         res_core_o,
  output logic [PMU_AW-1:0]                     res_reg_o,
  output logic                                  last_o
);
  localparam int CW = $clog2(CORE_COUNT);

  logic              active_q, sample_q, valid_q;
  logic [CW-1:0]     core_q;
  logic [PMU_AW-1:0] reg_q;
  logic [PMU_DW-1:0] data_q;
  logic              accept, last_word;

  assign accept    = valid_q & res_ready_i;
  assign last_word = (core_q == CW'(CORE_COUNT - 1)) &&
                     (reg_q == PMU_AW'(PMU_REG_COUNT - 1));
  assign last_o    = accept & last_word;

  // sample_q marks the cycle after the select moved: data is taken then,
  // giving the PMU a full cycle of address-to-data time.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      active_q <= 1'b0;
      sample_q <= 1'b0;
      valid_q  <= 1'b0;
      core_q   <= '0;
      reg_q    <= '0;
      data_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      sample_q <= 1'b1;
      valid_q  <= 1'b0;
      core_q   <= '0;
      reg_q    <= '0;
    end else if (active_q) begin
      if (sample_q) begin
        data_q   <= pmu_data_i[core_q];
        valid_q  <= 1'b1;
        sample_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b0;
        if (last_word) begin
          active_q <= 1'b0;
        end else begin
          sample_q <= 1'b1;
          if (reg_q == PMU_AW'(PMU_REG_COUNT - 1)) begin
            reg_q  <= '0;
            core_q <= core_q + 1'b1;
          end else begin
            reg_q <= reg_q + 1'b1;
          end
        end
      end
    end
  end

  // Only the core under read sees a non-zero select.
  always_comb begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      pmu_addr_o[c] = '0;
      if (active_q && core_q == CW'(c)) pmu_addr_o[c] = reg_q;
    end
  end

  assign res_valid_o = valid_q;
  assign res_data_o  = data_q;
  assign res_core_o  = core_q;
  assign res_reg_o   = reg_q;
endmodule

// File: rtl/loader_sequencer.sv
// Loader sequencer: accepts per-core loader descriptors, starts the loaders,
// waits for them to go idle (or time out), then drains every core's PMU
// registers as a stream of result words.
//   clk_i, arstn_i                 : clock, async active-low reset
//   desc_*                         : descriptor handshake and fields
//   run_i / busy_o / done_o        : run control and status
//   timeout_o / bad_desc_o         : sticky status, cleared on run accept
//   resp_wait/id/write/axlen_o     : per-core descriptor fields
//   fifo_push_o                    : per-core push pulse
//   start_o / idle_i               : loader start pulse, loader idle
//   pmu_addr_o / pmu_data_i        : per-core PMU access
//   res_*                          : drained PMU words
module loader_sequencer
  import loader_sequencer_pkg::*;
#(
  parameter int CORE_COUNT     = 16,
  parameter int AXI_ID_WIDTH   = 5,
  parameter int PMU_REG_COUNT  = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                    clk_i,
  input  logic                                    arstn_i,
  input  logic                                    desc_valid_i,
  output logic                                    desc_ready_o,
  input  logic [$clog2(CORE_COUNT)-1:0]           desc_core_i,
  input  logic [AXI_ID_WIDTH-1:0]                 desc_id_i,
  input  logic                                    desc_write_i,
  input  logic [7:0]                              desc_axlen_i,
  input  logic                                    desc_resp_wait_i,
  input  logic                                    run_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    timeout_o,
  output logic                                    bad_desc_o,
  output logic [CORE_COUNT-1:0]                   resp_wait_o,
  output logic [CORE_COUNT-1:0][AXI_ID_WIDTH-1:0] id_o,
  output logic [CORE_COUNT-1:0]                   write_o,
  output logic [CORE_COUNT-1:0][7:0]              axlen_o,
  output logic [CORE_COUNT-1:0]                   fifo_push_o,
  output logic                                    start_o,
  input  logic [CORE_COUNT-1:0]                   idle_i,
  output logic [CORE_COUNT-1:0][PMU_AW-1:0]       pmu_addr_o,
  input  logic [CORE_COUNT-1:0][PMU_DW-1:0]       pmu_data_i,
  output logic                                    res_valid_o,
  input  logic                                    res_ready_i,
  output logic [PMU_DW-1:0]                       res_data_o,
  output logic [$clog2(CORE_COUNT)-1:0]           res_core_o,
  output logic [PMU_AW-1:0]                       res_reg_o
);
  localparam int CW = $clog2(CORE_COUNT);

  state_e      state_q, state_d;
  logic        hs, core_ok, push_ok, run_ok, all_idle;
  logic        settle_q, idle_seen_q, timeout_hit, drain_start, walk_last;
  logic [31:0] wait_cnt_q;
  logic        timeout_q, bad_q;

  assign hs       = desc_valid_i & desc_ready_o;
  // Extra bit so non-power-of-two core counts can flag out-of-range cores.
  assign core_ok  = {1'b0, desc_core_i} < (CW + 1)'(CORE_COUNT);
  assign push_ok  = hs & core_ok;
  assign run_ok   = run_i & (state_q == ST_LOAD);
  assign all_idle = &idle_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= ST_LOAD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_LOAD:   if (run_i) state_d = ST_START;
      ST_START:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_q) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        // A clean idle pair wins over a timeout landing in the same cycle.
        if (all_idle && idle_seen_q) begin
          state_d = ST_DRAIN;
        end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_DRAIN;
          timeout_hit = 1'b1;
        end
      end
      ST_DRAIN:  if (walk_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_LOAD;
      default:   state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    // Gate with reset so the handshake is closed while reset is held.
    desc_ready_o = (state_q == ST_LOAD) & arstn_i;
    start_o      = (state_q == ST_START);
    busy_o       = (state_q != ST_LOAD);
    done_o       = (state_q == ST_DONE);
    drain_start  = (state_q == ST_WAIT_IDLE) & (state_d == ST_DRAIN);
  end

  // Settle and idle/timeout tracking restart from zero on every entry.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      settle_q    <= 1'b0;
      idle_seen_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      settle_q <= (state_q == ST_SETTLE) & ~settle_q;
      if (state_q == ST_WAIT_IDLE) begin
        wait_cnt_q  <= wait_cnt_q + 32'd1;
        idle_seen_q <= all_idle;
      end else begin
        wait_cnt_q  <= '0;
        idle_seen_q <= 1'b0;
      end
    end
  end

  // Sticky flags: run acceptance clears, a same-cycle set still wins.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      timeout_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      if (run_ok) begin
        timeout_q <= 1'b0;
        bad_q     <= 1'b0;
      end
      if (timeout_hit)    timeout_q <= 1'b1;
      if (hs && !core_ok) bad_q     <= 1'b1;
    end
  end

  assign timeout_o  = timeout_q;
  assign bad_desc_o = bad_q;

  // Per-core descriptor fields, updated together with the push pulse.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      fifo_push_o <= '0;
      resp_wait_o <= '0;
      id_o        <= '0;
      write_o     <= '0;
      axlen_o     <= '0;
    end else begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        fifo_push_o[c] <= push_ok && (desc_core_i == CW'(c));
        if (push_ok && desc_core_i == CW'(c)) begin
          resp_wait_o[c] <= desc_resp_wait_i;
          id_o[c]        <= desc_id_i;
          write_o[c]     <= desc_write_i;
          axlen_o[c]     <= desc_axlen_i;
        end
      end
    end
  end

  pmu_drain_walker #(
    .CORE_COUNT   (CORE_COUNT),
    .PMU_REG_COUNT(PMU_REG_COUNT)
  ) u_walker (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .start_i    (drain_start),
    .pmu_addr_o (pmu_addr_o),
    .pmu_data_i (pmu_data_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o (res_data_o),
    .res_core_o (res_core_o),
    .res_reg_o  (res_reg_o),
    .last_o     (walk_last)
  );
endmodule

// File: tb/tb_loader_sequencer.sv
module tb_loader_sequencer;
  localparam int CC = 16, IW = 5, PR = 8, TO = 100;
  localparam int SC = 6, SR = 2;

  logic clk_i = 1'b0;
  logic arstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // main instance
  logic desc_valid_i = 0, desc_write_i = 0, desc_resp_wait_i = 0, run_i = 0;
  logic [3:0] desc_core_i = '0;
  logic [IW-1:0] desc_id_i = '0;
  logic [7:0] desc_axlen_i = '0;
  logic desc_ready_o, busy_o, done_o, timeout_o, bad_desc_o, start_o;
  logic [CC-1:0] resp_wait_o, write_o, fifo_push_o;
  logic [CC-1:0][IW-1:0] id_o;
  logic [CC-1:0][7:0] axlen_o;
  logic [CC-1:0] idle_i = '1;
  logic [CC-1:0][4:0] pmu_addr_o;
  logic [CC-1:0][31:0] pmu_data_i;
  logic res_valid_o, res_ready_i;
  logic [31:0] res_data_o;
  logic [3:0] res_core_o;
  logic [4:0] res_reg_o;

  // small instance: non-power-of-two core count makes out-of-range cores encodable
  logic s_valid = 0, s_run = 0, s_zero = 0, s_one = 1;
  logic [2:0] s_core = '0;
  logic [IW-1:0] s_id = '0;
  logic [7:0] s_axlen = '0;
  logic s_ready, s_busy, s_done, s_timeout, s_bad, s_start, s_res_valid;
  logic [SC-1:0] s_resp_wait, s_write, s_push;
  logic [SC-1:0] s_idle = '1;
  logic [SC-1:0][IW-1:0] s_id_o;
  logic [SC-1:0][7:0] s_axlen_o;
  logic [SC-1:0][4:0] s_addr;
  logic [SC-1:0][31:0] s_data = '0;
  logic [31:0] s_res_data;
  logic [2:0] s_res_core;
  logic [4:0] s_res_reg;

  loader_sequencer #(.CORE_COUNT(CC), .AXI_ID_WIDTH(IW), .PMU_REG_COUNT(PR), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_core_i(desc_core_i), .desc_id_i(desc_id_i), .desc_write_i(desc_write_i),
    .desc_axlen_i(desc_axlen_i), .desc_resp_wait_i(desc_resp_wait_i), .run_i(run_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .bad_desc_o(bad_desc_o),
    .resp_wait_o(resp_wait_o), .id_o(id_o), .write_o(write_o), .axlen_o(axlen_o),
    .fifo_push_o(fifo_push_o), .start_o(start_o), .idle_i(idle_i), .pmu_addr_o(pmu_addr_o),
    .pmu_data_i(pmu_data_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_core_o(res_core_o), .res_reg_o(res_reg_o));

  loader_sequencer #(.CORE_COUNT(SC), .AXI_ID_WIDTH(IW), .PMU_REG_COUNT(SR), .TIMEOUT_CYCLES(TO)) u_small (
    .clk_i(clk_i), .arstn_i(arstn_i), .desc_valid_i(s_valid), .desc_ready_o(s_ready),
    .desc_core_i(s_core), .desc_id_i(s_id), .desc_write_i(s_zero), .desc_axlen_i(s_axlen),
    .desc_resp_wait_i(s_zero), .run_i(s_run), .busy_o(s_busy), .done_o(s_done),
    .timeout_o(s_timeout), .bad_desc_o(s_bad), .resp_wait_o(s_resp_wait), .id_o(s_id_o),
    .write_o(s_write), .axlen_o(s_axlen_o), .fifo_push_o(s_push), .start_o(s_start),
    .idle_i(s_idle), .pmu_addr_o(s_addr), .pmu_data_i(s_data), .res_valid_o(s_res_valid),
    .res_ready_i(s_one), .res_data_o(s_res_data), .res_core_o(s_res_core), .res_reg_o(s_res_reg));

  // PMU model: register r of core c reads c*256 + r
  always_comb begin
    for (int c = 0; c < CC; c++) pmu_data_i[c] = 32'(c * 256) + 32'(pmu_addr_o[c]);
  end

  typedef struct { int core; int rg; logic [31:0] data; } word_t;
  typedef struct { int core; int id; logic wr; int axlen; logic rw; } push_t;
  word_t sb[$];
  push_t pq[$];

  int checks = 0, failures = 0;
  int start_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int ready_mode = 1;  // 0 low, 1 high, 2 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    res_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      res_ready_i = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // monitor: result words, push pulses, start/done pulses
  initial begin
    logic hold_prev;
    logic [40:0] prev_word;
    hold_prev = 0;
    prev_word = '0;
    forever begin
      @(negedge clk_i);
      if (!arstn_i) begin
        hold_prev = 0;
      end else begin
        if (start_o) start_cnt++;
        if (done_o) done_cnt++;
        if (hold_prev) begin
          check("hold_valid", 64'(res_valid_o), 64'd1);
          check("hold_word", 64'({res_core_o, res_reg_o, res_data_o}), 64'(prev_word));
        end
        if (res_valid_o && res_ready_i) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_word actual core=%0d reg=%0d expected none", res_core_o, res_reg_o);
          end else begin
            word_t e;
            int nz;
            e = sb.pop_front();
            check("word_core", 64'(res_core_o), 64'(e.core));
            check("word_reg", 64'(res_reg_o), 64'(e.rg));
            check("word_data", 64'(res_data_o), 64'(e.data));
            nz = 0;
            for (int c = 0; c < CC; c++) if (c != int'(res_core_o) && pmu_addr_o[c] != 0) nz++;
            check("other_addr_zero", 64'(nz), 64'd0);
            acc_cnt++;
          end
        end
        hold_prev = res_valid_o && !res_ready_i;
        prev_word = {res_core_o, res_reg_o, res_data_o};
        if (|fifo_push_o) begin
          if (pq.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_push actual=%0h expected none", fifo_push_o);
          end else begin
            push_t p;
            p = pq.pop_front();
            check("push_onehot", 64'(fifo_push_o), 64'(1) << p.core);
            check("push_id", 64'(id_o[p.core]), 64'(p.id));
            check("push_write", 64'(write_o[p.core]), 64'(p.wr));
            check("push_axlen", 64'(axlen_o[p.core]), 64'(p.axlen));
            check("push_resp", 64'(resp_wait_o[p.core]), 64'(p.rw));
          end
        end
      end
    end
  end

  task automatic send(input int core, input int id, input logic wr, input int len, input logic rw);
    push_t p;
    p = '{core, id, wr, len, rw};
    pq.push_back(p);
    desc_valid_i = 1; desc_core_i = 4'(core); desc_id_i = IW'(id);
    desc_write_i = wr; desc_axlen_i = 8'(len); desc_resp_wait_i = rw;
    tick();
    desc_valid_i = 0;
  endtask

  task automatic load_words();
    for (int c = 0; c < CC; c++)
      for (int r = 0; r < PR; r++) begin
        word_t w;
        w = '{c, r, 32'(c * 256 + r)};
        sb.push_back(w);
      end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin @(negedge clk_i); n++; end
    check(name, 64'(done_o), 64'd1);
    @(negedge clk_i);
    check({name, "_one_cycle"}, 64'(done_o), 64'd0);
    check({name, "_idle"}, 64'({busy_o, desc_ready_o}), 64'b01);
  endtask

  initial begin
    int k;
    int dsave;
    // reset state
    #12;
    check("rst_outs", 64'({desc_ready_o, busy_o, done_o, start_o, timeout_o, bad_desc_o, res_valid_o}), 64'd0);
    check("rst_fields", 64'({fifo_push_o, write_o, resp_wait_o}), 64'd0);
    tick(); arstn_i = 1;
    @(negedge clk_i);
    check("ready_after_rst", 64'({desc_ready_o, busy_o}), 64'b10);

    // descriptor pushes
    send(3, 5, 1, 7, 1);
    send(0, 1, 0, 0, 0);
    send(15, 31, 1, 255, 0);
    tick(); tick();
    check("hold_id3", 64'(id_o[3]), 64'd5);
    check("hold_axlen3", 64'(axlen_o[3]), 64'd7);
    check("hold_wr3", 64'(write_o[3]), 64'd1);
    check("untouched_id4", 64'(id_o[4]), 64'd0);
    check("push_queue_empty", 64'(pq.size()), 64'd0);

    // out-of-range core on the 6-core instance
    s_valid = 1; s_core = 3'd6; s_id = 5'd3;
    tick(); s_valid = 0;
    @(negedge clk_i);
    check("bad_no_push", 64'(s_push), 64'd0);
    check("bad_set", 64'(s_bad), 64'd1);
    tick();
    s_valid = 1; s_core = 3'd5; s_id = 5'd9;
    tick(); s_valid = 0;
    @(negedge clk_i);
    check("small_push5", 64'(s_push), 64'h20);
    check("small_id5", 64'(s_id_o[5]), 64'd9);
    check("bad_sticky", 64'(s_bad), 64'd1);
    tick();
    s_run = 1; tick(); s_run = 0;
    @(negedge clk_i);
    check("bad_clear_on_run", 64'({s_bad, s_busy}), 64'b01);
    k = 0;
    while (!s_done && k < 200) begin @(negedge clk_i); k++; end
    check("small_done", 64'(s_done), 64'd1);

    // full run under random backpressure, idle from the first wait cycle
    tick();
    ready_mode = 2; idle_i = '1; load_words();
    run_i = 1; tick(); run_i = 0;
    @(negedge clk_i);
    check("start_pulse", 64'({start_o, busy_o}), 64'b11);
    k = 0;
    while (!res_valid_o && k < 50) begin @(negedge clk_i); k++; end
    check("start_to_first_word", 64'(k), 64'd6);
    tick(); run_i = 1; tick(); run_i = 0;  // ignored outside LOAD
    wait_done("run1_done", 3000);
    check("run1_words_left", 64'(sb.size()), 64'd0);
    check("run1_starts", 64'(start_cnt), 64'd1);
    check("run1_timeout", 64'(timeout_o), 64'd0);

    // timeout with core 7 never idle
    tick();
    ready_mode = 1; idle_i = '1; idle_i[7] = 1'b0; load_words();
    run_i = 1; tick(); run_i = 0;
    @(negedge clk_i);
    check("to_start", 64'(start_o), 64'd1);
    k = 0;
    while (!timeout_o && k < 200) begin
      @(negedge clk_i); k++;
      if (res_valid_o && !timeout_o) check("word_before_timeout", 64'd1, 64'(timeout_o));
    end
    check("start_to_timeout", 64'(k), 64'd103);
    wait_done("run2_done", 1000);
    check("run2_words_left", 64'(sb.size()), 64'd0);
    check("timeout_sticky", 64'(timeout_o), 64'd1);
    check("run2_starts", 64'(start_cnt), 64'd2);

    // reset in the middle of a drain
    tick();
    idle_i = '1; load_words();
    run_i = 1; tick(); run_i = 0;
    @(negedge clk_i);
    check("timeout_clear_on_run", 64'(timeout_o), 64'd0);
    k = 0;
    while (acc_cnt < 256 + 5 && k < 100) begin @(negedge clk_i); k++; end
    check("mid_drain_reached", 64'(acc_cnt >= 261), 64'd1);
    dsave = done_cnt;
    tick(); arstn_i = 0; sb.delete();
    #1;
    check("mrst_status", 64'({desc_ready_o, busy_o, done_o, start_o, timeout_o, res_valid_o}), 64'd0);
    check("mrst_addr", 64'(pmu_addr_o[0]) | 64'(pmu_addr_o[1]), 64'd0);
    check("mrst_id", 64'(id_o[3]), 64'd0);
    check("mrst_axlen", 64'(axlen_o[15]), 64'd0);
    repeat (3) tick();
    arstn_i = 1;
    repeat (10) tick();
    @(negedge clk_i);
    check("mrst_no_done", 64'(done_cnt), 64'(dsave));
    check("mrst_back_load", 64'({desc_ready_o, busy_o, res_valid_o}), 64'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
